connect_vec_serializer: RTL
===========================

CONNECT_VEC_SERIALIZER -- requirements
Module: connect_vec_serializer

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, meaning element width in bits.
REQ-002 The block SHALL have parameter NUM_ELEM, default 9, meaning elements per vector (3x3x1 pool window); legal range 2..256.
REQ-003 The block SHALL have localparam IDX_W = clog2(NUM_ELEM), meaning element index width.
REQ-004 clk  in  1  sole clock, all state updates on the rising edge.
REQ-005 rst  in  1  synchronous reset, active-high.
REQ-006 in_valid  in  1  input vector offered.
REQ-007 in_ready  out  1  block accepts a vector this cycle.
REQ-008 in_vec  in  NUM_ELEM*DATA_W  packed vector; element k at bits [k*DATA_W +: DATA_W].
REQ-009 in_rev  in  1  stream order for this vector: 0 = index 0 first, 1 = index NUM_ELEM-1 first.
REQ-010 out_valid  out  1  out_data valid.
REQ-011 out_ready  in  1  consumer accepts the element.
REQ-012 out_data  out  DATA_W  current element.
REQ-013 out_idx  out  IDX_W  element index of out_data within the vector.
REQ-014 out_last  out  1  high with the final element of a vector.

Function
REQ-015 The block SHALL implement a two-state FSM, IDLE and STREAM.
REQ-016 Input handshake: a vector is accepted on a cycle with in_valid && in_ready; in_vec and in_rev are registered and the FSM enters STREAM.
REQ-017 in_ready SHALL be 1 in IDLE, and in STREAM only on the final-element output handshake (out_valid && out_ready && out_last); 0 otherwise.
REQ-018 On acceptance the index counter SHALL load 0 (in_rev=0) or NUM_ELEM-1 (in_rev=1).
REQ-019 out_valid SHALL be 1 in every STREAM cycle, beginning the cycle after acceptance (latency 1 cycle), and 0 in IDLE.
REQ-020 out_data SHALL equal the registered element at out_idx, selected combinationally from the latched vector.
REQ-021 On each output handshake that is not the final element, the index SHALL step +1 (forward) or -1 (reverse).
REQ-022 out_last SHALL be 1 when out_idx = NUM_ELEM-1 (forward) or 0 (reverse), else 0.
REQ-023 While out_valid && !out_ready, out_data, out_idx and out_last SHALL hold stable.
REQ-024 Final-element handshake without a new vector: FSM returns to IDLE next cycle, out_valid drops.
REQ-025 Final-element handshake with in_valid=1 (back-to-back): the new vector SHALL be accepted that same cycle and streaming continues with no bubble; a full vector then occupies exactly NUM_ELEM cycles at out_ready=1.
REQ-026 in_vec changes outside an accepting cycle SHALL NOT affect output.
REQ-027 Index counter SHALL never leave 0..NUM_ELEM-1; out_idx and out_data are 0 in IDLE.

Reset
REQ-028 With rst=1 at a clock edge: FSM to IDLE, out_valid=0, out_idx=0, out_data=0, out_last=0, latched vector cleared; in_ready=1 from the following cycle.
REQ-029 Reset mid-STREAM SHALL discard the remaining elements with no further output handshake.
REQ-030 During a reset cycle in_ready SHALL be 0 and no vector is accepted.

Structure
REQ-031 Defaults DATA_W=8, NUM_ELEM=9 and the FSM state encoding SHALL live in shared package connect_pkg.
REQ-032 Element selection SHALL be the sub-module connect_elem_mux (parameters DATA_W, NUM_ELEM; inputs vector, index; output element; out-of-range index yields 0).

Verification
REQ-033 Forward: in_vec bytes 0x10..0x18 (elem k = 0x10+k), in_rev=0, out_ready=1 -> out_data 0x10..0x18 over 9 consecutive cycles, out_last only with 0x18/idx 8.
REQ-034 Reverse: same vector, in_rev=1 -> 0x18..0x10, out_idx 8..0, out_last with idx 0.
REQ-035 Backpressure: out_ready low 3 cycles at idx 4 -> out_data 0x14 held 4 cycles, then 0x15; total 12 cycles, no loss.
REQ-036 Back-to-back: second vector 0x20..0x28 held valid during first stream -> in_ready pulses only with 0x18 handshake; 0x20 follows next cycle, 18 beats in 18 cycles.
REQ-037 Reset at idx 5 -> next cycle out_valid=0, outputs 0; new vector then streams from idx 0.
REQ-038 Parameter sweep NUM_ELEM=2 and 16, DATA_W=16 -> forward/reverse order and out_last correct.

Source files
------------

// File: rtl/connect_pkg.sv
// -----------------------------------------------------------------------------
// connect_pkg
// Shared definitions for the vector serializer: default element width,
// default elements per vector (3x3x1 pool window) and the FSM state encoding.
// No ports (package).
// -----------------------------------------------------------------------------
package connect_pkg;

  localparam int CONNECT_DATA_W   = 8;
  localparam int CONNECT_NUM_ELEM = 9;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_STREAM = 1'b1
  } state_e;

endpackage : connect_pkg

// File: rtl/connect_elem_mux.sv
// -----------------------------------------------------------------------------
// connect_elem_mux
// Combinational element selector: returns element 'index' of a packed vector.
// An index outside 0..NUM_ELEM-1 yields zero.
// Ports:
//   vector  in  NUM_ELEM*DATA_W  packed vector, element k at [k*DATA_W +: DATA_W]
//   index   in  IDX_W            element to select
//   element out DATA_W           selected element
// -----------------------------------------------------------------------------
module connect_elem_mux
  import connect_pkg::*;
#(
  parameter  int DATA_W   = CONNECT_DATA_W,
  parameter  int NUM_ELEM = CONNECT_NUM_ELEM,
  localparam int IDX_W    = $clog2(NUM_ELEM)
) (
  input  logic [NUM_ELEM*DATA_W-1:0] vector,
  input  logic [IDX_W-1:0]           index,
  output logic [DATA_W-1:0]          element
);

  // NOTE: every always_comb output gets a default before any conditional
  // assignment, otherwise an unmatched index would infer a latch.
  always_comb begin
    element = '0;
    for (int k = 0; k < NUM_ELEM; k++) begin
      if (index == IDX_W'(k)) element = vector[k*DATA_W +: DATA_W];
    end
  end

endmodule : connect_elem_mux

// File: rtl/connect_vec_serializer.sv
// -----------------------------------------------------------------------------
// connect_vec_serializer
// Accepts a packed vector of NUM_ELEM elements and streams it out one element
// per handshake, forward (index 0 first) or reverse (index NUM_ELEM-1 first).
// A new vector can be accepted on the final-element handshake so consecutive
// vectors stream without a bubble.
// Ports:
//   clk        in   1                sole clock, rising edge
//   rst        in   1                synchronous reset, active-high
//   in_valid   in   1                input vector offered
//   in_ready   out  1                vector accepted this cycle
//   in_vec     in   NUM_ELEM*DATA_W  packed input vector
//   in_rev     in   1                0 = forward order, 1 = reverse order
//   out_valid  out  1                out_data valid
//   out_ready  in   1                consumer accepts the element
//   out_data   out  DATA_W           current element
//   out_idx    out  IDX_W            index of out_data within the vector
//   out_last   out  1                final element of the vector
// -----------------------------------------------------------------------------
module connect_vec_serializer
  import connect_pkg::*;
#(
  parameter  int DATA_W   = CONNECT_DATA_W,
  parameter  int NUM_ELEM = CONNECT_NUM_ELEM,
  localparam int IDX_W    = $clog2(NUM_ELEM)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [NUM_ELEM*DATA_W-1:0] in_vec,
  input  logic                       in_rev,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_W-1:0]          out_data,
  output logic [IDX_W-1:0]           out_idx,
  output logic                       out_last
);

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_ELEM - 1);

  state_e                      state_q, state_d;
  logic [NUM_ELEM*DATA_W-1:0]  vec_q,   vec_d;
  logic                        rev_q,   rev_d;
  logic [IDX_W-1:0]            idx_q,   idx_d;

  logic [DATA_W-1:0] elem;
  logic              out_fire;
  logic              last_fire;
  logic              accept;

  connect_elem_mux #(
    .DATA_W   (DATA_W),
    .NUM_ELEM (NUM_ELEM)
  ) u_elem_mux (
    .vector  (vec_q),
    .index   (idx_q),
    .element (elem)
  );

  // Outputs and next state. in_ready is combinational on out_ready so the
  // final-element handshake and the next acceptance share one cycle.
  always_comb begin
    state_d   = state_q;
    vec_d     = vec_q;
    rev_d     = rev_q;
    idx_d     = idx_q;

    out_valid = (state_q == ST_STREAM);
    out_last  = out_valid && (rev_q ? (idx_q == '0) : (idx_q == IDX_LAST));
    out_fire  = out_valid && out_ready;
    last_fire = out_fire && out_last;
    in_ready  = !rst && ((state_q == ST_IDLE) || last_fire);
    accept    = in_valid && in_ready;

    // idx_q keeps its final value after a stream ends; gate it off in IDLE.
    out_idx   = out_valid ? idx_q : '0;
    out_data  = out_valid ? elem  : '0;

    case (state_q)
      ST_IDLE: begin
        if (accept) state_d = ST_STREAM;
      end
      ST_STREAM: begin
        if (last_fire && !accept) state_d = ST_IDLE;
        else if (out_fire && !out_last) idx_d = rev_q ? idx_q - IDX_W'(1) : idx_q + IDX_W'(1);
      end
      default: state_d = ST_IDLE;
    endcase

    if (accept) begin
      vec_d = in_vec;
      rev_d = in_rev;
      idx_d = in_rev ? IDX_LAST : '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only; the reset is
  // synchronous, so it lives inside the clocked branch rather than the
  // sensitivity list. The latched vector is a plain register, so it is
  // cleared here along with the control state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      vec_q   <= '0;
      rev_q   <= 1'b0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      rev_q   <= rev_d;
      idx_q   <= idx_d;
    end
  end

endmodule : connect_vec_serializer
